// File: rtl/sd_pkg.sv
// Shared state encodings, status codes and widths for the SD sector sequencer.
package sd_pkg;

  localparam int unsigned SECTOR_W = 32;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StIssue,
    StWaitRise,
    StWaitFall,
    StDrain,
    StNext,
    StFinish
  } seq_state_e;

  typedef enum logic [1:0] {
    SD_ST_OK        = 2'd0,
    SD_ST_START_TMO = 2'd1,
    SD_ST_BUSY_TMO  = 2'd2,
    SD_ST_ABORT     = 2'd3
  } sd_status_e;

  // A count field of zero stands for a full 256-sector transfer.
  function automatic logic [8:0] decode_count(input logic [7:0] count);
    return (count == 8'd0) ? 9'd256 : {1'b0, count};
  endfunction

endpackage

// File: rtl/sd_seq_timer.sv
// Loadable down-counter that saturates at zero; shared by the start window and the busy timeout.
module sd_seq_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             expired_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/sd_sector_sequencer.sv
// Multi-sector SD transfer sequencer: one command in, one sd_rw start per sector, with buffer
// hand-off to the CPU side, start retry, start/busy timeouts and abort.
module sd_sector_sequencer
  import sd_pkg::*;
#(
  parameter int unsigned TMO_W      = 24,
  parameter int unsigned START_WAIT = 16,
  parameter int unsigned RETRIES    = 2
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_write_i,
  input  logic [SECTOR_W-1:0] cmd_lba_i,
  input  logic [7:0]          cmd_count_i,
  input  logic                abort_i,
  output logic                buf_req_o,
  input  logic                buf_ack_i,
  output logic                eng_rstart_o,
  output logic                eng_wstart_o,
  output logic [SECTOR_W-1:0] eng_sector_o,
  input  logic                eng_busy_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [1:0]          status_o,
  output logic [8:0]          remaining_o
);

  localparam int unsigned StartW = $clog2(START_WAIT + 1);
  localparam int unsigned TimerW = (TMO_W > StartW) ? TMO_W : StartW;
  localparam int unsigned RetryW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
  // Loads are two short of the window: one cycle for the load, one for the expiry decision.
  localparam logic [TimerW-1:0] StartLoad = TimerW'(START_WAIT - 2);
  localparam logic [TimerW-1:0] BusyLoad  = TimerW'((64'd1 << TMO_W) - 64'd2);

  seq_state_e          state_q, state_d;
  sd_status_e          status_q, status_d;
  logic                write_q, write_d;
  logic [SECTOR_W-1:0] sector_q, sector_d;
  logic [8:0]          remaining_q, remaining_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic                abort_pend_q, abort_pend_d;

  logic              abort_now;
  logic              timer_load;
  logic [TimerW-1:0] timer_val;
  logic              timer_expired;
  logic              rstart, wstart;

  sd_seq_timer #(
    .Width(TimerW)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .expired_o  (timer_expired)
  );

  assign abort_now = abort_i | abort_pend_q;

  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    write_d      = write_q;
    sector_d     = sector_q;
    remaining_d  = remaining_q;
    retry_d      = retry_q;
    abort_pend_d = abort_pend_q | (abort_i & (state_q != StIdle));
    timer_load   = 1'b0;
    timer_val    = StartLoad;
    rstart       = 1'b0;
    wstart       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          write_d      = cmd_write_i;
          sector_d     = cmd_lba_i;
          remaining_d  = decode_count(cmd_count_i);
          status_d     = SD_ST_OK;
          retry_d      = '0;
          abort_pend_d = 1'b0;
          state_d      = cmd_write_i ? StFill : StIssue;
        end
      end
      StFill: begin
        if (abort_now) begin
          status_d = SD_ST_ABORT;
          state_d  = StFinish;
        end else if (buf_ack_i) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        // Reload every cycle so the start window counts from the actual pulse.
        timer_load = 1'b1;
        timer_val  = StartLoad;
        if (abort_now) begin
          status_d = SD_ST_ABORT;
          state_d  = StFinish;
        end else if (!eng_busy_i) begin
          rstart  = ~write_q;
          wstart  = write_q;
          state_d = StWaitRise;
        end
      end
      StWaitRise: begin
        if (eng_busy_i) begin
          timer_load = 1'b1;
          timer_val  = BusyLoad;
          state_d    = StWaitFall;
        end else if (timer_expired) begin
          if (retry_q < RetryW'(RETRIES)) begin
            retry_d = retry_q + RetryW'(1);
            state_d = StIssue;
          end else begin
            status_d = SD_ST_START_TMO;
            state_d  = StFinish;
          end
        end
      end
      StWaitFall: begin
        if (!eng_busy_i) begin
          if (abort_now) begin
            status_d = SD_ST_ABORT;
            state_d  = StFinish;
          end else begin
            state_d = write_q ? StNext : StDrain;
          end
        end else if (timer_expired) begin
          status_d = SD_ST_BUSY_TMO;
          state_d  = StFinish;
        end
      end
      StDrain: begin
        if (abort_now) begin
          status_d = SD_ST_ABORT;
          state_d  = StFinish;
        end else if (buf_ack_i) begin
          state_d = StNext;
        end
      end
      StNext: begin
        if (abort_now) begin
          status_d = SD_ST_ABORT;
          state_d  = StFinish;
        end else begin
          remaining_d = remaining_q - 9'd1;
          sector_d    = sector_q + SECTOR_W'(1);
          retry_d     = '0;
          if (remaining_q == 9'd1) begin
            state_d = StFinish;
          end else begin
            state_d = write_q ? StFill : StIssue;
          end
        end
      end
      StFinish: begin
        abort_pend_d = 1'b0;
        state_d      = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= StIdle;
      status_q     <= SD_ST_OK;
      write_q      <= 1'b0;
      sector_q     <= '0;
      remaining_q  <= '0;
      retry_q      <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      write_q      <= write_d;
      sector_q     <= sector_d;
      remaining_q  <= remaining_d;
      retry_q      <= retry_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign cmd_ready_o  = (state_q == StIdle);
  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StFinish);
  assign buf_req_o    = (state_q == StFill) || (state_q == StDrain);
  assign eng_rstart_o = rstart;
  assign eng_wstart_o = wstart;
  assign eng_sector_o = sector_q;
  assign status_o     = status_q;
  assign remaining_o  = remaining_q;

endmodule
